// File: rtl/cache_mem_responder_if.sv
// Request/response bus between the cache miss path (master) and the
// backing-memory responder (slave).
interface cache_mem_responder_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic          resp_is_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_addr, resp_data, resp_is_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_addr, resp_data, resp_is_wr
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Backing-memory responder for the cache miss path. Owns a 2^AW x DW memory
// image, serves one read-fill or write-back at a time, and answers after
// LATENCY cycles (legal range 1..15; the countdown is 4 bits wide).
// Optional feature macro: CACHE_MEM_WR_ACK_EN -- when defined, write-backs
// return an acknowledge beat; when undefined, writes are posted.
module cache_mem_responder #(
    parameter int LATENCY = 4,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_mem_responder_if.slave   bus,
    output logic                   busy
);
    localparam int         DEPTH  = 1 << AW;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          accept;
    logic          wr_en;
    logic          load_resp;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] resp_addr_reg;
    logic [DW-1:0] resp_data_reg;
    logic [DW-1:0] mem [DEPTH];
`ifdef CACHE_MEM_WR_ACK_EN
    logic          we_reg;
    logic          resp_is_wr_reg;
`endif

    // State register and latency counter; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic, countdown and acceptance/write/response-load strobes.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        wr_en      = 1'b0;
        load_resp  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    wr_en  = bus.req_we;
`ifdef CACHE_MEM_WR_ACK_EN
                    state_next = ST_WAIT;
                    cnt_next   = LAT_M1;
`else
                    // Posted writes never leave IDLE, so writes stream every cycle.
                    if (!bus.req_we) begin
                        state_next = ST_WAIT;
                        cnt_next   = LAT_M1;
                    end
`endif
                end
            end
            ST_WAIT: begin
                // Leave at zero instead of decrementing so the counter never wraps.
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                    load_resp  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory image: identity pattern on reset, written on write acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DW'(i);
            end
        end else if (wr_en) begin
            mem[bus.req_addr] <= bus.req_wdata;
        end
    end

    // Request capture and response field registers (stable while in RESP).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg       <= '0;
            resp_addr_reg  <= '0;
            resp_data_reg  <= '0;
`ifdef CACHE_MEM_WR_ACK_EN
            we_reg         <= 1'b0;
            resp_is_wr_reg <= 1'b0;
`endif
        end else begin
            if (accept) begin
                addr_reg <= bus.req_addr;
`ifdef CACHE_MEM_WR_ACK_EN
                we_reg   <= bus.req_we;
`endif
            end
            if (load_resp) begin
                resp_addr_reg  <= addr_reg;
`ifdef CACHE_MEM_WR_ACK_EN
                resp_data_reg  <= we_reg ? '0 : mem[addr_reg];
                resp_is_wr_reg <= we_reg;
`else
                resp_data_reg  <= mem[addr_reg];
`endif
            end
        end
    end

    // Handshake outputs decode the state register only (no path from req_valid).
    assign bus.req_ready  = (state_reg == ST_IDLE);
    assign bus.resp_valid = (state_reg == ST_RESP);
    assign bus.resp_addr  = resp_addr_reg;
    assign bus.resp_data  = resp_data_reg;
`ifdef CACHE_MEM_WR_ACK_EN
    assign bus.resp_is_wr = resp_is_wr_reg;
`else
    assign bus.resp_is_wr = 1'b0;
`endif
    assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: two instances (LATENCY 4 and 1),
// expected beats queued at request acceptance, checked by per-instance monitors.
`timescale 1ns/1ps
module tb_cache_mem_responder;
    localparam int LAT_A = 4;
    localparam int LAT_B = 1;
`ifdef CACHE_MEM_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       is_wr;
        int         rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy_a, busy_b;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   was_a = 0, idle_a = 0;
    bit   was_b = 0, idle_b = 0;

    cache_mem_responder_if #(.AW(8), .DW(8)) ia ();
    cache_mem_responder_if #(.AW(8), .DW(8)) ib ();

    cache_mem_responder #(.LATENCY(LAT_A), .AW(8), .DW(8)) dut_a (
        .clk (clk), .rst (rst), .bus (ia.slave), .busy (busy_a)
    );
    cache_mem_responder #(.LATENCY(LAT_B), .AW(8), .DW(8)) dut_b (
        .clk (clk), .rst (rst), .bus (ib.slave), .busy (busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int d, input logic v, input logic we,
                           input logic [7:0] a, input logic [7:0] wd);
        if (d == 0) begin
            ia.req_valid = v; ia.req_we = we; ia.req_addr = a; ia.req_wdata = wd;
        end else begin
            ib.req_valid = v; ib.req_we = we; ib.req_addr = a; ib.req_wdata = wd;
        end
    endtask

    // Present a request, hold it until accepted, queue the expected beat.
    task automatic issue(input int d, input logic we, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] exp_d, output int acc);
        exp_t e;
        bit   ok = 0;
        set_req(d, 1'b1, we, a, wd);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((d == 0) ? ia.req_ready : ib.req_ready) begin
                ok = 1;
                break;
            end
        end
        chk(d == 0 ? "a_req_accepted" : "b_req_accepted", 32'(ok), 32'd1);
        acc     = cyc;
        e.addr  = a;
        e.data  = we ? 8'h00 : exp_d;
        e.is_wr = we;
        e.rise  = cyc + 1 + ((d == 0) ? LAT_A : LAT_B);
        if (!we || ACK) begin
            if (d == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        @(posedge clk); #1;
        set_req(d, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic drain(input int d);
        int sz;
        sz = (d == 0) ? q_a.size() : q_b.size();
        for (int k = 0; k < 200 && sz != 0; k++) begin
            @(negedge clk);
            sz = (d == 0) ? q_a.size() : q_b.size();
        end
        chk(d == 0 ? "a_drain" : "b_drain", 32'(sz), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset();
        chk("rst_req_ready",  32'(ia.req_ready),  32'd1);
        chk("rst_resp_valid", 32'(ia.resp_valid), 32'd0);
        chk("rst_resp_addr",  32'(ia.resp_addr),  32'd0);
        chk("rst_resp_data",  32'(ia.resp_data),  32'd0);
        chk("rst_resp_is_wr", 32'(ia.resp_is_wr), 32'd0);
        chk("rst_busy",       32'(busy_a),        32'd0);
    endtask

    // Monitor for instance A: latency, field stability, ready after handshake.
    always @(negedge clk) begin
        if (!rst) begin
            was_a = 0; idle_a = 0;
        end else begin
            if (idle_a) begin
                chk("a_ready_after_hs", 32'(ia.req_ready), 32'd1);
                idle_a = 0;
            end
            if (ia.resp_valid) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_beat", 32'(ia.resp_valid), 32'd0);
                end else begin
                    if (!was_a) chk("a_latency", 32'(cyc), 32'(q_a[0].rise));
                    chk("a_resp_addr",  32'(ia.resp_addr),  32'(q_a[0].addr));
                    chk("a_resp_data",  32'(ia.resp_data),  32'(q_a[0].data));
                    chk("a_resp_is_wr", 32'(ia.resp_is_wr), 32'(q_a[0].is_wr));
                    chk("a_ready_in_resp", 32'(ia.req_ready), 32'd0);
                    if (ia.resp_ready) begin
                        $display("[A] cyc=%0d addr=%02h data=%02h wr=%0b",
                                 cyc, ia.resp_addr, ia.resp_data, ia.resp_is_wr);
                        void'(q_a.pop_front());
                        idle_a = 1;
                    end
                end
            end
            was_a = ia.resp_valid;
        end
    end

    // Monitor for instance B (LATENCY 1).
    always @(negedge clk) begin
        if (!rst) begin
            was_b = 0; idle_b = 0;
        end else begin
            if (idle_b) begin
                chk("b_ready_after_hs", 32'(ib.req_ready), 32'd1);
                idle_b = 0;
            end
            if (ib.resp_valid) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_beat", 32'(ib.resp_valid), 32'd0);
                end else begin
                    if (!was_b) chk("b_latency", 32'(cyc), 32'(q_b[0].rise));
                    chk("b_resp_addr", 32'(ib.resp_addr), 32'(q_b[0].addr));
                    chk("b_resp_data", 32'(ib.resp_data), 32'(q_b[0].data));
                    if (ib.resp_ready) begin
                        $display("[B] cyc=%0d addr=%02h data=%02h wr=%0b",
                                 cyc, ib.resp_addr, ib.resp_data, ib.resp_is_wr);
                        void'(q_b.pop_front());
                        idle_b = 1;
                    end
                end
            end
            was_b = ib.resp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2;
        logic [7:0] sweep [5];
        sweep[0] = 8'h00; sweep[1] = 8'h01; sweep[2] = 8'h7F;
        sweep[3] = 8'hFE; sweep[4] = 8'hFF;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        ia.resp_ready = 1'b1;
        ib.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;

        // Read after reset: identity data.
        issue(0, 1'b0, 8'h3C, 8'h00, 8'h3C, acc1);
        drain(0);

        // Write-back then read of the same address.
        issue(0, 1'b1, 8'h10, 8'hA5, 8'h00, acc1);
        issue(0, 1'b0, 8'h10, 8'h00, 8'hA5, acc2);
        chk("a_wr_rd_spacing", 32'(acc2 - acc1), ACK ? 32'(LAT_A + 2) : 32'd1);
        drain(0);

        // Backpressure: stall the 0xFF read for 10 cycles, second read held.
        ia.resp_ready = 1'b0;
        issue(0, 1'b0, 8'hFF, 8'h00, 8'hFF, acc1);
        fork
            issue(0, 1'b0, 8'h21, 8'h00, 8'h21, acc2);
            begin
                repeat (LAT_A + 10) @(posedge clk);
                #1 ia.resp_ready = 1'b1;
            end
        join
        chk("a_held_req_spacing", 32'(acc2 - acc1), 32'(LAT_A + 12));
        drain(0);

        // Reset two cycles into WAIT aborts the read and restores memory.
        issue(0, 1'b1, 8'h80, 8'h00, 8'h00, acc1);
        drain(0);
        issue(0, 1'b0, 8'h80, 8'h00, 8'h00, acc2);
        @(posedge clk);
        @(posedge clk); #1;
        chk("a_busy_in_wait", 32'(busy_a), 32'd1);
        rst = 1'b0;
        q_a.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_reset();
        repeat (6) @(posedge clk);
        #1;
        chk("a_no_resp_after_abort", 32'(ia.resp_valid), 32'd0);
        issue(0, 1'b0, 8'h80, 8'h00, 8'h80, acc1);
        drain(0);

        // LATENCY=1 sweep on instance B.
        for (int i = 0; i < 5; i++) begin
            issue(1, 1'b0, sweep[i], 8'h00, sweep[i], acc1);
        end
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Backing-memory responder that sits on the far side of the cache's miss path. It owns the 256 x 8 main-memory image, accepts one read-fill or write-back request at a time over a valid/ready handshake, waits a configurable number of cycles to model memory latency, and returns the data on a valid/ready response channel. The cache controller is the only initiator, and this block is the only responder.

## Interface
- LATENCY, 4: cycles from request acceptance to response valid; legal range 1..15.
- AW, 8: address width; memory depth is 2^AW.
- DW, 8: data width.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write-back, 0 = read-fill.
- req_addr  in  AW  memory address.
- req_wdata  in  DW  write data; ignored for reads.
- resp_valid  out  1  response beat present.
- resp_ready  in  1  initiator accepts the response.
- resp_addr  out  AW  address of the request being answered.
- resp_data  out  DW  read data; 0 for write acknowledges.
- resp_is_wr  out  1  response is a write acknowledge.
- busy  out  1  a request is outstanding (state != IDLE).

## Operation
- Reset is asynchronous: `rst`=0 immediately forces the FSM to IDLE and clears the latency counter.
  - Reset outputs: `req_ready`=1, `resp_valid`=0, `resp_addr`=0, `resp_data`=0, `resp_is_wr`=0, `busy`=0.
  - The memory image is reloaded to mem[i] = i[DW-1:0] for all i.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid` && `req_ready`, capture addr/we/wdata, load the counter with LATENCY-1, and go to WAIT.
  - WAIT: count down. At 0, go to RESP. A read latches `resp_data` = mem[addr] on this transition.
  - RESP: `resp_valid`=1, and all resp_* fields are held stable. On `resp_ready`, return to IDLE.
- Write-backs update mem[addr] on the acceptance edge. A read issued after a write to the same address always returns the new data.
- Only one transaction is ever outstanding. `req_ready`=0 in WAIT and RESP. Requests presented then are neither accepted nor dropped; the initiator must hold them.
- Counter is 4 bits. It must not wrap: at 0 it transitions state rather than decrementing.
- Reset asserted mid-transaction (WAIT or RESP) aborts it: no response is issued, and the memory image reverts to its reset contents.

## Timing
- Request accepted at rising edge N (IDLE, `req_valid`=1).
- `resp_valid` rises after edge N+LATENCY.
- The earliest new acceptance is the edge after the one where `resp_valid` && `resp_ready`. This gives a minimum of LATENCY+2 cycles per transaction when `resp_ready` is held high.
- `resp_ready` held low: the response stalls indefinitely with fields unchanged.
- `req_ready` is a registered function of state only; it has no combinational path from `req_valid`.
- LATENCY=1: WAIT lasts exactly one cycle.

## Configuration
- `CACHE_MEM_WR_ACK_EN` defined:
  - Writes pass through WAIT and RESP like reads.
  - They produce one response beat with `resp_is_wr`=1 and `resp_data`=0.
- `CACHE_MEM_WR_ACK_EN` undefined:
  - Writes are posted. The memory is updated at acceptance and the FSM stays in IDLE, so `req_ready` remains 1 and back-to-back writes are accepted every cycle.
  - No response is generated for writes, and `resp_is_wr` is tied to 0.

## Test plan
- Read after reset, LATENCY=4, addr=0x3C, `resp_ready`=1:
  - `resp_valid` rises 4 cycles after acceptance, with `resp_data`=0x3C and `resp_addr`=0x3C.
  - `req_ready` returns to 1 the next cycle.
- Write 0xA5 to 0x10, then read 0x10:
  - The read returns 0xA5.
  - With `CACHE_MEM_WR_ACK_EN`, one ack beat with `resp_is_wr`=1 appears first. Without it, there is no ack, and the write and read are accepted on consecutive cycles.
- Backpressure: hold `resp_ready`=0 for 10 cycles during a read of 0xFF.
  - `resp_valid` and `resp_data`=0xFF stay stable throughout.
  - `req_ready` stays 0, and a held second request is accepted only after the handshake.
- Reset mid-WAIT: write 0x00 to 0x80, then read 0x80, and assert `rst`=0 two cycles into WAIT.
  - `resp_valid` never rises.
  - After reset release, a read of 0x80 returns 0x80.
- LATENCY=1 sweep over addresses 0x00, 0x01, 0x7F, 0xFE, 0xFF:
  - Each response arrives exactly 1 cycle after acceptance, with data equal to the address.
